// File: rtl/iob_pbus_arbiter.sv
// ============================================================================
// Module      : iob_pbus_arbiter
// Description : Round-robin arbiter sharing one IOb-native slave port between
//               N_MASTERS IOb requesters. One transaction is outstanding at a
//               time. The bus is released on ready for writes and on rvalid
//               for reads.
//               Optional response watchdog: define IOB_PBUS_ARBITER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_pbus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT_W = 10
) (
  input  logic                             clk_i,
  input  logic                             cke_i,
  input  logic                             arst_i,
  input  logic [N_MASTERS-1:0]             m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]      m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]      m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]  m_wstrb_i,
  output logic [N_MASTERS-1:0]             m_ready_o,
  output logic [N_MASTERS-1:0]             m_rvalid_o,
  output logic [DATA_W-1:0]                m_rdata_o,
  output logic                             s_valid_o,
  output logic [ADDR_W-1:0]                s_addr_o,
  output logic [DATA_W-1:0]                s_wdata_o,
  output logic [DATA_W/8-1:0]              s_wstrb_o,
  input  logic                             s_ready_i,
  input  logic                             s_rvalid_i,
  input  logic [DATA_W-1:0]                s_rdata_i,
  output logic [N_MASTERS-1:0]             grant_o,
  output logic                             timeout_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);

  // Reject illegal configurations at elaboration time
  if (N_MASTERS < 2 || TIMEOUT_W < 1) begin : g_param_check
    $error("iob_pbus_arbiter: N_MASTERS must be >= 2 and TIMEOUT_W >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;

  // Request fields of the currently granted master
  logic                 g_valid;
  logic [ADDR_W-1:0]    g_addr;
  logic [DATA_W-1:0]    g_wdata;
  logic [STRB_W-1:0]    g_wstrb;

  // Round-robin arbitration result
  logic                 hi_found, lo_found;
  logic [IDX_W-1:0]     hi_idx, lo_idx, win_idx;
  logic [N_MASTERS-1:0] win_onehot;

  logic                 wd_expired;

`ifdef IOB_PBUS_ARBITER_TIMEOUT_EN
  localparam logic [DATA_W-1:0] DEAD_DATA = DATA_W'(32'hDEAD_BEEF);

  logic [TIMEOUT_W-1:0] wd_q;

  // Watchdog: held at zero while idle, so it restarts on every entry to REQ
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wd_q <= '0;
    end else if (cke_i) begin
      if (state_q == S_IDLE) wd_q <= '0;
      else                   wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_expired = (state_q != S_IDLE) && (wd_q == {TIMEOUT_W{1'b1}});
`else
  localparam logic [DATA_W-1:0] DEAD_DATA = '0;

  assign wd_expired = 1'b0;
`endif

  // AND-OR mux of the granted master's request (grant is one-hot or zero)
  always_comb begin
    g_valid = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_valid = g_valid | m_valid_i[i];
        g_addr  = g_addr  | m_addr_i[i*ADDR_W +: ADDR_W];
        g_wdata = g_wdata | m_wdata_i[i*DATA_W +: DATA_W];
        g_wstrb = g_wstrb | m_wstrb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  // Pick the first requester after last, wrapping to the lowest index
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (m_valid_i[i]) begin
        if (IDX_W'(i) > last_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDX_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < N_MASTERS; i++) begin
      win_onehot[i] = (IDX_W'(i) == win_idx);
    end
  end

  // Next-state logic: one transaction at a time, always back through IDLE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|m_valid_i) begin
          state_d = S_REQ;
          grant_d = win_onehot;
          last_d  = win_idx;
        end
      end
      S_REQ: begin
        if (wd_expired || !g_valid) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (s_ready_i) begin
          if (|g_wstrb) begin
            state_d = S_IDLE;
            grant_d = '0;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (wd_expired || s_rvalid_i) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and last-granted registers; frozen while cke_i is low
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Output steering driven from the registered state
  always_comb begin
    s_valid_o  = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    case (state_q)
      S_REQ: begin
        s_valid_o = g_valid & ~wd_expired;
        s_addr_o  = g_addr;
        s_wdata_o = g_wdata;
        s_wstrb_o = g_wstrb;
        m_ready_o = grant_q & {N_MASTERS{s_ready_i | wd_expired}};
      end
      S_RESP: begin
        m_rvalid_o = grant_q & {N_MASTERS{s_rvalid_i | wd_expired}};
        m_rdata_o  = wd_expired ? DEAD_DATA : s_rdata_i;
      end
      default: begin
        s_valid_o = 1'b0;
      end
    endcase
  end

  assign grant_o   = grant_q;
  assign timeout_o = wd_expired;

endmodule

`default_nettype wire
